// File: rtl/c1541_track_ctrl.sv
// Track buffer sequencer for the 1541 GCR path: loads the head's track from the D64 image
// into the buffer RAM and writes it back when it was modified.
module c1541_track_ctrl #(
  parameter int SETTLE_CYCLES = 32000
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic [5:0] track,
  input  logic       mtr,
  input  logic       gcr_we,
  output logic       ram_ready,
  output logic       dirty,
  output logic [9:0] sd_lba,
  output logic [4:0] buf_sector,
  output logic       sd_rd,
  output logic       sd_wr,
  input  logic       sd_ack,
  input  logic       sd_done,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETTLE     = 3'd1,
    S_LOAD_REQ   = 3'd2,
    S_LOAD_WAIT  = 3'd3,
    S_READY      = 3'd4,
    S_FLUSH_REQ  = 3'd5,
    S_FLUSH_WAIT = 3'd6
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    track_q;
  logic          mtr_q;
  logic [5:0]    xfer_track;
  logic [5:0]    loaded_track;
  logic          mount_pend;
  logic          abort_pend;
  logic          ret_ready;

  function automatic logic [4:0] track_sectors(input logic [5:0] t);
    if (t >= 6'd1 && t <= 6'd17)       return 5'd21;
    else if (t >= 6'd18 && t <= 6'd24) return 5'd19;
    else if (t >= 6'd25 && t <= 6'd30) return 5'd18;
    else if (t >= 6'd31 && t <= 6'd35) return 5'd17;
    else                               return 5'd0;
  endfunction

  function automatic logic [9:0] track_base(input logic [5:0] t);
    logic [9:0] tw;
    tw = {4'd0, t};
    if (t >= 6'd1 && t <= 6'd17)       return (tw - 10'd1) * 10'd21;
    else if (t >= 6'd18 && t <= 6'd24) return 10'd357 + (tw - 10'd18) * 10'd19;
    else if (t >= 6'd25 && t <= 6'd30) return 10'd490 + (tw - 10'd25) * 10'd18;
    else if (t >= 6'd31 && t <= 6'd35) return 10'd598 + (tw - 10'd31) * 10'd17;
    else                               return 10'd0;
  endfunction

  logic last_sector;
  logic track_valid;
  logic mount_now;
  logic abort_now;
  logic dirty_now;

  assign last_sector = (buf_sector == track_sectors(xfer_track) - 5'd1);
  assign track_valid = (track >= 6'd1) && (track <= 6'd35);
  assign mount_now   = mount_pend | img_mounted;
  assign abort_now   = abort_pend | (track != xfer_track);
  assign dirty_now   = dirty | gcr_we;

  // Request handshake: sd_rd/sd_wr is held high in its *_REQ state until the first
  // cycle sd_ack is seen; the transfer is then owned by the image side until sd_done.
  assign sd_rd     = (state == S_LOAD_REQ);
  assign sd_wr     = (state == S_FLUSH_REQ);
  assign ram_ready = (state == S_READY);
  assign sd_lba    = track_base(xfer_track) + {5'd0, buf_sector};
  assign state_dbg = state;

  always_ff @(posedge clk32) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      track_q      <= '0;
      mtr_q        <= 1'b0;
      xfer_track   <= '0;
      buf_sector   <= '0;
      loaded_track <= '0;
      dirty        <= 1'b0;
      mount_pend   <= 1'b0;
      abort_pend   <= 1'b0;
      ret_ready    <= 1'b0;
    end else begin
      track_q <= track;
      mtr_q   <= mtr;
      case (state)
        S_IDLE: begin
          if (img_mounted) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end

        S_SETTLE: begin
          if (img_mounted) begin
            dirty        <= 1'b0;
            loaded_track <= '0;
            cnt          <= '0;
          end else if (track != track_q) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            // An out-of-range track just parks here until the head moves somewhere real.
            if (track_valid) begin
              xfer_track <= track;
              buf_sector <= '0;
              abort_pend <= 1'b0;
              state      <= S_LOAD_REQ;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LOAD_REQ, S_LOAD_WAIT: begin
          if (img_mounted)           mount_pend <= 1'b1;
          if (track != xfer_track)   abort_pend <= 1'b1;
          if (state == S_LOAD_REQ) begin
            if (sd_ack) state <= S_LOAD_WAIT;
          end else if (sd_done) begin
            if (mount_now || abort_now) begin
              if (mount_now) dirty <= 1'b0;
              loaded_track <= '0;
              mount_pend   <= 1'b0;
              abort_pend   <= 1'b0;
              cnt          <= '0;
              state        <= S_SETTLE;
            end else if (last_sector) begin
              loaded_track <= xfer_track;
              dirty        <= 1'b0;
              state        <= S_READY;
            end else begin
              buf_sector <= buf_sector + 5'd1;
              state      <= S_LOAD_REQ;
            end
          end
        end

        S_READY: begin
          if (img_mounted) begin
            // A new image discards any writes still aimed at the old one.
            dirty        <= 1'b0;
            loaded_track <= '0;
            cnt          <= '0;
            state        <= S_SETTLE;
          end else begin
            if (gcr_we) dirty <= 1'b1;
            if (track != loaded_track) begin
              if (dirty_now && !img_readonly) begin
                xfer_track <= loaded_track;
                buf_sector <= '0;
                ret_ready  <= 1'b0;
                state      <= S_FLUSH_REQ;
              end else begin
                cnt   <= '0;
                state <= S_SETTLE;
              end
            end else if (mtr_q && !mtr && dirty_now && !img_readonly) begin
              xfer_track <= loaded_track;
              buf_sector <= '0;
              ret_ready  <= 1'b1;
              state      <= S_FLUSH_REQ;
            end
          end
        end

        S_FLUSH_REQ, S_FLUSH_WAIT: begin
          if (img_mounted) mount_pend <= 1'b1;
          if (state == S_FLUSH_REQ) begin
            if (sd_ack) state <= S_FLUSH_WAIT;
          end else if (sd_done) begin
            if (mount_now) begin
              dirty        <= 1'b0;
              loaded_track <= '0;
              mount_pend   <= 1'b0;
              cnt          <= '0;
              state        <= S_SETTLE;
            end else if (last_sector) begin
              dirty <= 1'b0;
              // The head may have moved during a motor-stop flush; then the buffer is stale.
              if (ret_ready && track == loaded_track) begin
                state <= S_READY;
              end else begin
                cnt   <= '0;
                state <= S_SETTLE;
              end
            end else begin
              buf_sector <= buf_sector + 5'd1;
              state      <= S_FLUSH_REQ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Bench for c1541_track_ctrl: an SD responder checks every accepted transfer against
// a queue of expected {wr, lba, sector} entries pushed by the test sequence.
module tb_c1541_track_ctrl;

  localparam int SETTLE = 16;

  logic       clk32 = 1'b0;
  logic       reset;
  logic       img_mounted;
  logic       img_readonly;
  logic [5:0] track;
  logic       mtr;
  logic       gcr_we;
  logic       ram_ready;
  logic       dirty;
  logic [9:0] sd_lba;
  logic [4:0] buf_sector;
  logic       sd_rd;
  logic       sd_wr;
  logic       sd_ack;
  logic       sd_done;
  logic [2:0] state_dbg;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;

  always #5 clk32 = ~clk32;

  c1541_track_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk32(clk32), .reset(reset), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .track(track), .mtr(mtr), .gcr_we(gcr_we), .ram_ready(ram_ready), .dirty(dirty),
    .sd_lba(sd_lba), .buf_sector(buf_sector), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_done(sd_done), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_xfer(input logic wr, input int first_lba, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({wr, 10'(first_lba + i), 5'(i)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    tick(2);
    while (!ram_ready && k < 3000) begin
      @(negedge clk32);
      k++;
    end
    chk({tag, "_ready"}, 32'(ram_ready), 32'd1);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_acks(input string tag, input int target);
    int k;
    k = 0;
    while (ack_cnt < target && k < 3000) begin
      @(negedge clk32);
      k++;
    end
    chk({tag, "_acks"}, 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic pulse_mount();
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_we();
    gcr_we = 1'b1;
    tick(1);
    gcr_we = 1'b0;
  endtask

  // SD image side: random ack latency, done at least two cycles after ack.
  initial begin
    logic [15:0] exp_e;
    sd_ack  = 1'b0;
    sd_done = 1'b0;
    forever begin
      @(posedge clk32); #1;
      if (sd_rd || sd_wr) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk32); #1; end
        if (sd_rd || sd_wr) begin
          chk("rdwr_excl", 32'(sd_rd & sd_wr), 32'd0);
          chk("ready_in_xfer", 32'(ram_ready), 32'd0);
          chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            chk("xfer", {16'd0, sd_wr, sd_lba, buf_sector}, {16'd0, exp_e});
          end
          sd_ack = 1'b1;
          ack_cnt++;
          @(posedge clk32); #1;
          sd_ack = 1'b0;
          repeat ($urandom_range(2, 4)) begin @(posedge clk32); #1; end
          sd_done = 1'b1;
          @(posedge clk32); #1;
          sd_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset = 1'b1; img_mounted = 1'b0; img_readonly = 1'b0;
    track = 6'd1; mtr = 1'b1; gcr_we = 1'b0;
    tick(3);
    chk("rst_ready", 32'(ram_ready), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    chk("rst_rd", 32'(sd_rd), 32'd0);
    chk("rst_wr", 32'(sd_wr), 32'd0);
    chk("rst_lba", 32'(sd_lba), 32'd0);
    chk("rst_sector", 32'(buf_sector), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick(40);
    chk("idle_no_mount", 32'(state_dbg), 32'd0);

    // Track 1 load after settle
    push_xfer(1'b0, 0, 21);
    pulse_mount();
    tick(SETTLE - 4);
    chk("settle_no_rd", 32'(sd_rd), 32'd0);
    wait_ready("t1");
    chk("t1_dirty", 32'(dirty), 32'd0);

    // Zone boundaries: tracks 18 and 35
    push_xfer(1'b0, 357, 19);
    track = 6'd18;
    wait_ready("t18");
    push_xfer(1'b0, 666, 17);
    track = 6'd35;
    wait_ready("t35");

    // Dirty track change flushes old track then loads new one
    push_xfer(1'b0, 0, 21);
    track = 6'd1;
    wait_ready("t1b");
    pulse_we();
    tick(1);
    chk("we_dirty", 32'(dirty), 32'd1);
    push_xfer(1'b1, 0, 21);
    push_xfer(1'b0, 21, 21);
    track = 6'd2;
    wait_ready("flush_t2");
    chk("flush_t2_dirty", 32'(dirty), 32'd0);

    // Read-only: dirty retained, never flushed
    pulse_we();
    img_readonly = 1'b1;
    tick(3);
    chk("ro_dirty_kept", 32'(dirty), 32'd1);
    mtr = 1'b0;
    tick(20);
    chk("ro_no_flush_ready", 32'(ram_ready), 32'd1);
    chk("ro_no_flush_dirty", 32'(dirty), 32'd1);
    mtr = 1'b1;
    tick(2);
    push_xfer(1'b0, 42, 21);
    track = 6'd3;
    wait_ready("ro_t3");
    chk("ro_t3_dirty", 32'(dirty), 32'd0);
    img_readonly = 1'b0;

    // Track change while sector 5 of track 4 is in flight
    push_xfer(1'b0, 63, 6);
    a0 = ack_cnt;
    track = 6'd4;
    wait_acks("abort", a0 + 6);
    push_xfer(1'b0, 84, 21);
    track = 6'd5;
    wait_ready("abort_t5");

    // Motor stop with dirty buffer
    pulse_we();
    push_xfer(1'b1, 84, 21);
    mtr = 1'b0;
    wait_ready("mtr_flush");
    chk("mtr_flush_dirty", 32'(dirty), 32'd0);

    // Remount during a motor-stop flush
    mtr = 1'b1;
    tick(3);
    pulse_we();
    push_xfer(1'b1, 84, 4);
    a0 = ack_cnt;
    mtr = 1'b0;
    wait_acks("mnt_flush", a0 + 4);
    push_xfer(1'b0, 84, 21);
    pulse_mount();
    wait_ready("mnt_reload");
    chk("mnt_reload_dirty", 32'(dirty), 32'd0);

    // Mount and gcr_we in the same cycle
    mtr = 1'b1;
    tick(3);
    push_xfer(1'b0, 84, 21);
    img_mounted = 1'b1;
    gcr_we = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    gcr_we = 1'b0;
    chk("mnt_we_dirty", 32'(dirty), 32'd0);
    chk("mnt_we_ready", 32'(ram_ready), 32'd0);
    wait_ready("mnt_we");

    // Invalid track parks in SETTLE, then track 17
    track = 6'd0;
    tick(3 * SETTLE + 5);
    chk("trk0_ready", 32'(ram_ready), 32'd0);
    chk("trk0_state", 32'(state_dbg), 32'd1);
    push_xfer(1'b0, 336, 21);
    track = 6'd17;
    wait_ready("t17");

    // Reset in the middle of a load
    push_xfer(1'b0, 395, 3);
    a0 = ack_cnt;
    track = 6'd20;
    wait_acks("rst_mid", a0 + 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_mid_state", 32'(state_dbg), 32'd0);
    chk("rst_mid_rd", 32'(sd_rd), 32'd0);
    chk("rst_mid_ready", 32'(ram_ready), 32'd0);
    tick(40);
    chk("rst_mid_idle", 32'(state_dbg), 32'd0);
    chk("rst_mid_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
